feature_buffer_responder: RTL and testbench
===========================================

Name: feature_buffer_responder

Overview:
Responder end of the feature-buffer read/write interface. MM and the other compute engines drive this interface as initiators: they issue avalid/addr and receive valid/data, and they issue write valid/addr/data. The block owns one feature bank (for example bank 2A) and serves two independent read request ports and one write port. Reads complete with a fixed latency.

Parameters:
ADDR_W, 11, address width of each port
DATA_W, 512, word width
DEPTH, 2048, number of words; legal range is 1..2**ADDR_W
READ_LATENCY, 2, cycles from rd*_avalid to rd*_valid; legal range is 1..4

Ports:
kernel_clk  in  1  single clock
kernel_rst  in  1  synchronous reset, active high
rd0_avalid  in  1  read request, port 0 (input-feature reads)
rd0_addr  in  ADDR_W  read address, port 0
rd0_valid  out  1  read data valid, port 0
rd0_data  out  DATA_W  read data, port 0
rd1_avalid  in  1  read request, port 1 (accumulate read-back)
rd1_addr  in  ADDR_W  read address, port 1
rd1_valid  out  1  read data valid, port 1
rd1_data  out  DATA_W  read data, port 1
wr_valid  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
busy  out  1  at least one read is in flight on either port
err_oob  out  1  sticky out-of-range access flag

Behaviour:
- Reset values: rd0_valid=0, rd1_valid=0, rd0_data=0, rd1_data=0, busy=0, err_oob=0.
- Memory contents are not reset.
- No backpressure. A request is accepted in every cycle its avalid is high, and back-to-back requests on every cycle are legal.
- Each read port has a READ_LATENCY-deep valid/address shift pipeline.
  - If avalid is high at edge T, then rd*_valid is high at edge T+READ_LATENCY, carrying the word sampled at edge T.
  - rd*_valid is asserted for exactly one cycle per request.
  - Requests return strictly in order.
- rd*_data holds its last returned value while rd*_valid is low. Consumers must qualify data with valid.
- Both read ports are served in the same cycle, with no arbitration between them. The bank is replicated or true-dual-port; that choice belongs to the implementation and must not be visible at the ports.
- Write: the array is updated at the edge where wr_valid is high. A write issued after edge T does not affect a read sampled at T.
- Same-cycle read and write to the same address: the read result is selected by the optional feature below.
- Out-of-range access: when addr >= DEPTH (only possible if DEPTH < 2**ADDR_W):
  - a read still returns valid on schedule, with data=0;
  - a write is dropped;
  - err_oob is set and stays set until kernel_rst.
- busy = OR of all valid-pipeline stages on both ports. It is combinational from registered state.
- Reset mid-operation:
  - all in-flight reads are discarded, and no rd*_valid pulse is issued for them;
  - a write coincident with kernel_rst high is ignored.
- Address arithmetic: none. Addresses are used as given, with no wrap. The initiator owns the start-address plus offset computation.

Optional Feature:
Macro FEATURE_BUFFER_WR_FORWARD_EN.
- Defined: a same-cycle rd*/wr hit on the same in-range address returns wr_data, giving write-first behaviour. The forward is decided per port.
- Undefined: such a hit returns the pre-write contents, giving read-first behaviour, and the forward mux is not present.
- The error and valid timing are identical in both builds.

Decomposition:
- Shared package feature_buffer_pkg holds:
  - the default ADDR_W/DATA_W/DEPTH constants;
  - a typedef for the address word;
  - a typedef for the data word;
  - the maximum READ_LATENCY limit of 4.
- One natural sub-module, feature_buffer_rd_pipe:
  - a per-port valid/data delay pipeline with an OOB-zero mux and an optional forward mux;
  - instantiated twice, once per read port.
- The top level holds the array, the write logic, busy and err_oob.

Test Plan:
- Basic write then read: write addr 5 = 0xA5 pattern, then rd0 addr 5 three cycles later -> rd0_valid exactly 2 cycles after request, rd0_data=0xA5 pattern, busy high for those 2 cycles.
- Streaming: rd0 addresses 0..63 on consecutive cycles after preloading mem[i]=i -> 64 consecutive rd0_valid pulses, data 0..63 in order, no gaps.
- Dual-port concurrency: rd0 addr 10 and rd1 addr 20 in the same cycle, with mem[10]=0x11 and mem[20]=0x22 -> both valid in the same cycle with data 0x11 and 0x22.
- Collision: mem[7]=0x1, then wr addr 7=0x2 and rd1 addr 7 in the same cycle -> with FEATURE_BUFFER_WR_FORWARD_EN, rd1_data=0x2; without it, rd1_data=0x1. A follow-up read returns 0x2 in both builds.
- Out of range: DEPTH=1000, read addr 1500 -> valid on schedule with data 0 and err_oob=1. Write to 1200 changes nothing. err_oob holds until kernel_rst.
- Reset mid-flight: issue rd0 at cycle T and assert kernel_rst at T+1 -> no rd0_valid at T+2, and all outputs return to reset values.

Source files
------------

// File: rtl/feature_buffer_pkg.sv
// Shared definitions for the feature-buffer responder.
// Holds the default geometry, the address/data word typedefs and the read-latency limit.
// The helper clamp_latency() keeps a stray READ_LATENCY inside the supported 1..4 window.
package feature_buffer_pkg;

  localparam int unsigned DefaultAddrW   = 11;
  localparam int unsigned DefaultDataW   = 512;
  localparam int unsigned DefaultDepth   = 2048;
  localparam int unsigned MaxReadLatency = 4;

  typedef logic [DefaultAddrW-1:0] fb_addr_t;
  typedef logic [DefaultDataW-1:0] fb_data_t;

  function automatic int unsigned clamp_latency(int unsigned lat);
    if (lat < 1) return 1;
    if (lat > MaxReadLatency) return MaxReadLatency;
    return lat;
  endfunction

endpackage

// File: rtl/feature_buffer_responder_if.sv
// Feature-buffer read/write bus between an initiator (MM or another compute engine) and the
// responder that owns one feature bank.
//   rd0_*   : read port 0 (input-feature reads), request avalid/addr, response valid/data
//   rd1_*   : read port 1 (accumulate read-back), same shape as port 0
//   wr_*    : write strobe, address and data
//   busy    : a read is in flight on either port
//   err_oob : sticky out-of-range access flag
// Modports: master = initiator side, slave = responder side.
interface feature_buffer_responder_if
  import feature_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
);

  logic              rd0_avalid;
  logic [ADDR_W-1:0] rd0_addr;
  logic              rd0_valid;
  logic [DATA_W-1:0] rd0_data;

  logic              rd1_avalid;
  logic [ADDR_W-1:0] rd1_addr;
  logic              rd1_valid;
  logic [DATA_W-1:0] rd1_data;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              busy;
  logic              err_oob;

  modport master (
    output rd0_avalid, rd0_addr, rd1_avalid, rd1_addr, wr_valid, wr_addr, wr_data,
    input  rd0_valid, rd0_data, rd1_valid, rd1_data, busy, err_oob
  );

  modport slave (
    input  rd0_avalid, rd0_addr, rd1_avalid, rd1_addr, wr_valid, wr_addr, wr_data,
    output rd0_valid, rd0_data, rd1_valid, rd1_data, busy, err_oob
  );

endinterface

// File: rtl/feature_buffer_rd_pipe.sv
// One read port's response pipeline: a LATENCY-deep valid/data shift chain.
// Stage 0 captures the word read in the request cycle (zeroed for out-of-range addresses);
// the last stage drives the port. Each data stage only loads behind a valid, so the
// output word holds its last returned value while valid is low.
// Optional macro FEATURE_BUFFER_WR_FORWARD_EN: a same-cycle write to the same address is
// forwarded into stage 0 (write-first); without it the pre-write word is kept (read-first).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   avalid, in_range    : request strobe and address-in-bank flag
//   mem_word            : array word at the request address, pre-write
//   addr, wr_* (opt.)   : request address and write port, forward build only
//   valid, data         : response to the initiator
//   inflight            : OR of all valid stages
module feature_buffer_rd_pipe
  import feature_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              avalid,
  input  logic              in_range,
  input  logic [DATA_W-1:0] mem_word,
`ifdef FEATURE_BUFFER_WR_FORWARD_EN
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              inflight
);

  logic [LATENCY-1:0]             v_q;
  logic [LATENCY-1:0][DATA_W-1:0] d_q;
  logic [DATA_W-1:0]              in_word;

`ifdef FEATURE_BUFFER_WR_FORWARD_EN
  logic fwd_hit;
  assign fwd_hit = wr_valid && (wr_addr == addr);
`endif

  always_comb begin
    in_word = mem_word;
`ifdef FEATURE_BUFFER_WR_FORWARD_EN
    if (fwd_hit) in_word = wr_data;
`endif
    // Out-of-range reads still return on schedule, with zero data.
    if (!in_range) in_word = '0;
  end

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    logic              v_in;
    logic [DATA_W-1:0] d_in;

    if (g == 0) begin : g_head
      assign v_in = avalid;
      assign d_in = in_word;
    end else begin : g_tail
      assign v_in = v_q[g-1];
      assign d_in = d_q[g-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[g] <= 1'b0;
        d_q[g] <= '0;
      end else begin
        v_q[g] <= v_in;
        if (v_in) d_q[g] <= d_in;
      end
    end
  end

  assign valid    = v_q[LATENCY-1];
  assign data     = d_q[LATENCY-1];
  assign inflight = |v_q;

endmodule

// File: rtl/feature_buffer_responder.sv
// Responder for one feature bank: the word array, the write port, two independent
// fixed-latency read ports, busy and the sticky out-of-range flag.
// Both read ports index the array combinationally in the same cycle, so there is no
// arbitration; the synthesis tool may map this onto a replicated or true-dual-port bank.
// Optional macro FEATURE_BUFFER_WR_FORWARD_EN selects write-first on a same-cycle
// read/write hit (default build: read-first).
// Ports:
//   kernel_clk : clock
//   kernel_rst : synchronous active-high reset
//   bus        : feature_buffer_responder_if.slave (rd0_*, rd1_*, wr_*, busy, err_oob)
module feature_buffer_responder
  import feature_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefaultAddrW,
  parameter int unsigned DATA_W       = DefaultDataW,
  parameter int unsigned DEPTH        = DefaultDepth,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                        kernel_clk,
  input  logic                        kernel_rst,
  feature_buffer_responder_if.slave   bus
);

  localparam int unsigned     Lat      = clamp_latency(READ_LATENCY);
  localparam int unsigned     IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic            rd0_in_range, rd1_in_range, wr_in_range;
  logic [IdxW-1:0] rd0_idx, rd1_idx, wr_idx;
  logic            rd0_inflight, rd1_inflight;
  logic            oob_event;
  logic            err_oob_q;

  // Compare one bit wider so DEPTH == 2**ADDR_W never flags anything.
  assign rd0_in_range = {1'b0, bus.rd0_addr} < DepthLim;
  assign rd1_in_range = {1'b0, bus.rd1_addr} < DepthLim;
  assign wr_in_range  = {1'b0, bus.wr_addr}  < DepthLim;

  assign rd0_idx = bus.rd0_addr[IdxW-1:0];
  assign rd1_idx = bus.rd1_addr[IdxW-1:0];
  assign wr_idx  = bus.wr_addr[IdxW-1:0];

  // Contents are not reset; a write coincident with reset is dropped.
  always_ff @(posedge kernel_clk) begin
    if (!kernel_rst && bus.wr_valid && wr_in_range) begin
      mem[wr_idx] <= bus.wr_data;
    end
  end

  assign oob_event = (bus.rd0_avalid && !rd0_in_range) ||
                     (bus.rd1_avalid && !rd1_in_range) ||
                     (bus.wr_valid   && !wr_in_range);

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      err_oob_q <= 1'b0;
    end else if (oob_event) begin
      err_oob_q <= 1'b1;
    end
  end

  feature_buffer_rd_pipe #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (Lat)
  ) u_rd0 (
    .clk      (kernel_clk),
    .rst      (kernel_rst),
    .avalid   (bus.rd0_avalid),
    .in_range (rd0_in_range),
    .mem_word (mem[rd0_idx]),
`ifdef FEATURE_BUFFER_WR_FORWARD_EN
    .addr     (bus.rd0_addr),
    .wr_valid (bus.wr_valid),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
`endif
    .valid    (bus.rd0_valid),
    .data     (bus.rd0_data),
    .inflight (rd0_inflight)
  );

  feature_buffer_rd_pipe #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (Lat)
  ) u_rd1 (
    .clk      (kernel_clk),
    .rst      (kernel_rst),
    .avalid   (bus.rd1_avalid),
    .in_range (rd1_in_range),
    .mem_word (mem[rd1_idx]),
`ifdef FEATURE_BUFFER_WR_FORWARD_EN
    .addr     (bus.rd1_addr),
    .wr_valid (bus.wr_valid),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
`endif
    .valid    (bus.rd1_valid),
    .data     (bus.rd1_data),
    .inflight (rd1_inflight)
  );

  assign bus.busy    = rd0_inflight | rd1_inflight;
  assign bus.err_oob = err_oob_q;

endmodule

// File: tb/tb_feature_buffer_responder.sv
// Self-checking bench for feature_buffer_responder (DEPTH=1000 so out-of-range paths exist).
// A queue-based model predicts every response; a compare process checks all outputs on
// each falling edge, and directed scenarios add hand-computed literal checks.
module tb_feature_buffer_responder;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 1000;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  feature_buffer_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  feature_buffer_responder #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (LAT)
  ) dut (
    .kernel_clk (clk),
    .kernel_rst (rst),
    .bus        (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void check1(string name, logic got, logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void check_int(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // ---------------- model ----------------
  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           q0[$];
  rd_t           q1[$];
  logic [DW-1:0] mm [int unsigned];
  int unsigned   cyc     = 0;
  bit            ready   = 1'b0;
  logic [DW-1:0] e_data0 = '0;
  logic [DW-1:0] e_data1 = '0;
  bit            e_err   = 1'b0;
  int            pulses0 = 0;

  function automatic logic [DW-1:0] model_read(logic [AW-1:0] a);
    int unsigned k;
    k = int'(a);
    if (k >= DEPTH) return '0;
`ifdef FEATURE_BUFFER_WR_FORWARD_EN
    if (bus.wr_valid && bus.wr_addr == a) return bus.wr_data;
`endif
    if (mm.exists(k)) return mm[k];
    return 'x;
  endfunction

  // Responses are due LAT edges after the request edge, i.e. visible LAT-1 cycles later.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      q0.delete();
      q1.delete();
      e_data0 = '0;
      e_data1 = '0;
      e_err   = 1'b0;
      ready   = 1'b1;
    end else begin
      if (bus.rd0_avalid) begin
        q0.push_back('{due: cyc + LAT - 1, data: model_read(bus.rd0_addr)});
        if (int'(bus.rd0_addr) >= DEPTH) e_err = 1'b1;
      end
      if (bus.rd1_avalid) begin
        q1.push_back('{due: cyc + LAT - 1, data: model_read(bus.rd1_addr)});
        if (int'(bus.rd1_addr) >= DEPTH) e_err = 1'b1;
      end
      if (bus.wr_valid) begin
        if (int'(bus.wr_addr) < DEPTH) mm[int'(bus.wr_addr)] = bus.wr_data;
        else e_err = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (ready) begin
      bit ev0, ev1, eb;
      eb  = (q0.size() != 0) || (q1.size() != 0);
      ev0 = (q0.size() != 0) && (q0[0].due == cyc);
      ev1 = (q1.size() != 0) && (q1[0].due == cyc);
      if (ev0) begin e_data0 = q0[0].data; void'(q0.pop_front()); end
      if (ev1) begin e_data1 = q1[0].data; void'(q1.pop_front()); end
      if (bus.rd0_valid === 1'b1) pulses0++;
      check1("m_rd0_valid", bus.rd0_valid, ev0);
      check1("m_rd1_valid", bus.rd1_valid, ev1);
      check("m_rd0_data", bus.rd0_data, e_data0);
      check("m_rd1_data", bus.rd1_data, e_data1);
      check1("m_busy", bus.busy, eb);
      check1("m_err_oob", bus.err_oob, e_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd0_avalid = 1'b0;
    bus.rd1_avalid = 1'b0;
    bus.wr_valid   = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  // Issues one request cycle and returns at the falling edge where the response is due.
  task automatic read_pair(input bit e0, input logic [AW-1:0] a0,
                           input bit e1, input logic [AW-1:0] a1,
                           input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bus.rd0_avalid = e0;
    bus.rd0_addr   = a0;
    bus.rd1_avalid = e1;
    bus.rd1_addr   = a1;
    bus.wr_valid   = we;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    tick();
    idle();
    @(negedge clk);
    check1("busy_mid", bus.busy, 1'b1);
    check1("valid_early", bus.rd0_valid | bus.rd1_valid, 1'b0);
    @(negedge clk);
  endtask

  logic [DW-1:0] exp_coll;
  int            p0;

  initial begin
    idle();
    bus.rd0_addr = '0;
    bus.rd1_addr = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check1("reset_rd0_valid", bus.rd0_valid, 1'b0);
    check1("reset_rd1_valid", bus.rd1_valid, 1'b0);
    check("reset_rd0_data", bus.rd0_data, 64'h0);
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_err", bus.err_oob, 1'b0);
    tick();

    // Basic write then read three cycles later.
    wr(11'd5, {8{8'hA5}});
    tick();
    tick();
    read_pair(1'b1, 11'd5, 1'b0, 11'd0, 1'b0, 11'd0, 64'h0);
    check1("basic_valid", bus.rd0_valid, 1'b1);
    check("basic_data", bus.rd0_data, 64'hA5A5_A5A5_A5A5_A5A5);
    check1("basic_busy", bus.busy, 1'b1);
    tick();
    @(negedge clk);
    check1("basic_one_pulse", bus.rd0_valid, 1'b0);
    check1("basic_busy_done", bus.busy, 1'b0);
    check("basic_data_hold", bus.rd0_data, 64'hA5A5_A5A5_A5A5_A5A5);
    tick();

    // Streaming 64 back-to-back reads.
    for (int i = 0; i < 64; i++) wr(AW'(i), DW'(i));
    p0 = pulses0;
    for (int i = 0; i < 64; i++) begin
      bus.rd0_avalid = 1'b1;
      bus.rd0_addr   = AW'(i);
      tick();
    end
    idle();
    repeat (4) tick();
    check_int("stream_pulses", pulses0 - p0, 64);
    check("stream_last_data", bus.rd0_data, 64'd63);

    // Both ports in the same cycle.
    wr(11'd10, 64'h11);
    wr(11'd20, 64'h22);
    read_pair(1'b1, 11'd10, 1'b1, 11'd20, 1'b0, 11'd0, 64'h0);
    check1("dual_v0", bus.rd0_valid, 1'b1);
    check1("dual_v1", bus.rd1_valid, 1'b1);
    check("dual_d0", bus.rd0_data, 64'h11);
    check("dual_d1", bus.rd1_data, 64'h22);
    tick();

    // Same-cycle read/write collision.
    wr(11'd7, 64'h1);
`ifdef FEATURE_BUFFER_WR_FORWARD_EN
    exp_coll = 64'h2;
`else
    exp_coll = 64'h1;
`endif
    read_pair(1'b0, 11'd0, 1'b1, 11'd7, 1'b1, 11'd7, 64'h2);
    check1("coll_valid", bus.rd1_valid, 1'b1);
    check("coll_data", bus.rd1_data, exp_coll);
    tick();
    read_pair(1'b0, 11'd0, 1'b1, 11'd7, 1'b0, 11'd0, 64'h0);
    check("coll_followup", bus.rd1_data, 64'h2);
    tick();

    // Out-of-range read and write.
    wr(11'd476, 64'h4444);
    wr(11'd176, 64'h1234);
    read_pair(1'b1, 11'd1500, 1'b0, 11'd0, 1'b0, 11'd0, 64'h0);
    check1("oob_valid", bus.rd0_valid, 1'b1);
    check("oob_data", bus.rd0_data, 64'h0);
    check1("oob_err", bus.err_oob, 1'b1);
    tick();
    wr(11'd1200, 64'hDEAD);
    read_pair(1'b1, 11'd176, 1'b0, 11'd0, 1'b0, 11'd0, 64'h0);
    check("oob_wr_dropped", bus.rd0_data, 64'h1234);
    tick();
    repeat (5) tick();
    @(negedge clk);
    check1("oob_err_sticky", bus.err_oob, 1'b1);
    tick();

    // Reset with a read in flight and a coincident write.
    wr(11'd3, 64'h33);
    bus.rd0_avalid = 1'b1;
    bus.rd0_addr   = 11'd3;
    tick();
    rst = 1'b1;
    idle();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 11'd3;
    bus.wr_data  = 64'h99;
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check1("rst_no_valid", bus.rd0_valid, 1'b0);
    check("rst_rd0_data", bus.rd0_data, 64'h0);
    check("rst_rd1_data", bus.rd1_data, 64'h0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_err", bus.err_oob, 1'b0);
    tick();
    @(negedge clk);
    check1("rst_no_late_valid", bus.rd0_valid, 1'b0);
    tick();
    read_pair(1'b1, 11'd3, 1'b0, 11'd0, 1'b0, 11'd0, 64'h0);
    check("rst_wr_ignored", bus.rd0_data, 64'h33);
    tick();

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
